// File: rtl/cricket_pkg.sv
// Shared types and delivery-outcome decoding for the cricket scorer.
// Contents:
//   state_t         innings sequencer states
//   OC_*            outcome codes with special meaning (extras, wickets)
//   outcome_t       decoded delivery {runs[2:0], legal, wicket}
//   decode_outcome  4-bit outcome code -> outcome_t
package cricket_pkg;

    typedef enum logic [1:0] {
        S_INN1 = 2'd0,
        S_INN2 = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OC_WIDE   = 4'd5;
    localparam logic [3:0] OC_NOBALL = 4'd7;
    localparam logic [3:0] OC_WKT_A  = 4'd8;
    localparam logic [3:0] OC_WKT_B  = 4'd12;

    typedef struct packed {
        logic [2:0] runs;
        logic       legal;
        logic       wicket;
    } outcome_t;

    // Extras (wide/no-ball) score one run but do not count as a legal ball.
    function automatic outcome_t decode_outcome(input logic [3:0] code);
        outcome_t r;
        r.runs   = 3'd0;
        r.legal  = 1'b1;
        r.wicket = 1'b0;
        case (code)
            4'd0:      r.runs = 3'd0;
            4'd1:      r.runs = 3'd1;
            4'd2:      r.runs = 3'd2;
            4'd3:      r.runs = 3'd3;
            4'd4:      r.runs = 3'd4;
            OC_WIDE: begin
                r.runs  = 3'd1;
                r.legal = 1'b0;
            end
            4'd6:      r.runs = 3'd6;
            OC_NOBALL: begin
                r.runs  = 3'd1;
                r.legal = 1'b0;
            end
            OC_WKT_A:  r.wicket = 1'b1;
            4'd9:      r.runs = 3'd1;
            4'd10:     r.runs = 3'd0;
            4'd11:     r.runs = 3'd2;
            OC_WKT_B:  r.wicket = 1'b1;
            4'd13:     r.runs = 3'd4;
            4'd14:     r.runs = 3'd1;
            4'd15:     r.runs = 3'd0;
            default:   r.runs = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/outcome_decoder.sv
// Combinational wrapper around decode_outcome so the decode table can be
// exercised on its own.
// Ports:
//   lfsr_out  in  4  delivery outcome code
//   runs      out 3  runs credited to the batting side
//   legal     out 1  delivery counts toward the innings ball limit
//   wicket    out 1  a wicket fell
module outcome_decoder
    import cricket_pkg::*;
(
    input  logic [3:0] lfsr_out,
    output logic [2:0] runs,
    output logic       legal,
    output logic       wicket
);

    outcome_t dec_s;

    // Decode the outcome code into its scoring fields.
    always_comb begin
        dec_s  = decode_outcome(lfsr_out);
        runs   = dec_s.runs;
        legal  = dec_s.legal;
        wicket = dec_s.wicket;
    end

endmodule

// File: rtl/innings_controller.sv
// Match-level scorer and innings sequencer. Applies one delivery per accepted
// ball_pulse to the batting team's runs/wickets/legal-ball counters and walks
// S_INN1 -> S_INN2 -> S_DONE, deciding winner or tie.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ball_pulse          one-cycle delivery strobe
//   lfsr_out[3:0]       delivery outcome code, sampled with ball_pulse
//   team_sw             deliveries ignored while high
//   new_match           synchronous clear; wins over a same-cycle ball_pulse
//   t1/t2_runs          run totals (saturating)
//   t1/t2_wkts          wickets fallen
//   t1/t2_legal         legal deliveries bowled
//   target              t1_runs+1 once innings 1 is over
//   inning_over         innings 1 finished
//   game_over, winner, tie  match result
//   ball_done           one-cycle pulse per applied delivery
//   last_outcome[3:0]   code of the last applied delivery
module innings_controller
    import cricket_pkg::*;
#(
    parameter int MAX_BALLS = 120,
    parameter int MAX_WKTS  = 10,
    parameter int RUN_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ball_pulse,
    input  logic [3:0]       lfsr_out,
    input  logic             team_sw,
    input  logic             new_match,
    output logic [RUN_W-1:0] t1_runs,
    output logic [RUN_W-1:0] t2_runs,
    output logic [3:0]       t1_wkts,
    output logic [3:0]       t2_wkts,
    output logic [7:0]       t1_legal,
    output logic [7:0]       t2_legal,
    output logic [RUN_W:0]   target,
    output logic             inning_over,
    output logic             game_over,
    output logic             winner,
    output logic             tie,
    output logic             ball_done,
    output logic [3:0]       last_outcome
);

    localparam logic [7:0] MAX_BALLS_C = 8'(MAX_BALLS);
    localparam logic [3:0] MAX_WKTS_C  = 4'(MAX_WKTS);

    state_t           state_r;
    logic [RUN_W-1:0] t1_runs_r, t2_runs_r;
    logic [3:0]       t1_wkts_r, t2_wkts_r;
    logic [7:0]       t1_legal_r, t2_legal_r;
    logic [RUN_W:0]   target_r;
    logic             inning_over_r, game_over_r, winner_r, tie_r, ball_done_r;
    logic [3:0]       last_outcome_r;

    logic [2:0]       runs_s;
    logic             legal_s, wicket_s, accept_s, end_s;
    logic [RUN_W-1:0] bat_runs_s, runs_next_s;
    logic [7:0]       bat_legal_s, legal_next_s;
    logic [3:0]       bat_wkts_s, wkts_next_s;

    // Run totals stick at all-ones instead of wrapping.
    function automatic logic [RUN_W-1:0] sat_add(input logic [RUN_W-1:0] a,
                                                  input logic [2:0]       b);
        logic [RUN_W:0] s;
        s = {1'b0, a} + {{(RUN_W-2){1'b0}}, b};
        if (s[RUN_W]) begin
            return '1;
        end else begin
            return s[RUN_W-1:0];
        end
    endfunction

    outcome_decoder u_dec (
        .lfsr_out (lfsr_out),
        .runs     (runs_s),
        .legal    (legal_s),
        .wicket   (wicket_s)
    );

    // Select the batting side and form its post-delivery counter values.
    always_comb begin
        accept_s = ball_pulse && !team_sw && (state_r != S_DONE);
        if (state_r == S_INN1) begin
            bat_runs_s  = t1_runs_r;
            bat_legal_s = t1_legal_r;
            bat_wkts_s  = t1_wkts_r;
        end else begin
            bat_runs_s  = t2_runs_r;
            bat_legal_s = t2_legal_r;
            bat_wkts_s  = t2_wkts_r;
        end
        runs_next_s  = sat_add(bat_runs_s, runs_s);
        legal_next_s = bat_legal_s + {7'd0, legal_s};
        wkts_next_s  = bat_wkts_s + {3'd0, wicket_s};
        end_s        = (legal_next_s == MAX_BALLS_C) || (wkts_next_s == MAX_WKTS_C);
    end

    // Innings FSM, score counters and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_INN1;
            t1_runs_r      <= '0;
            t2_runs_r      <= '0;
            t1_wkts_r      <= 4'd0;
            t2_wkts_r      <= 4'd0;
            t1_legal_r     <= 8'd0;
            t2_legal_r     <= 8'd0;
            target_r       <= '0;
            inning_over_r  <= 1'b0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
            tie_r          <= 1'b0;
            ball_done_r    <= 1'b0;
            last_outcome_r <= 4'd0;
        end else if (new_match) begin
            // Any delivery strobed in this cycle is discarded.
            state_r        <= S_INN1;
            t1_runs_r      <= '0;
            t2_runs_r      <= '0;
            t1_wkts_r      <= 4'd0;
            t2_wkts_r      <= 4'd0;
            t1_legal_r     <= 8'd0;
            t2_legal_r     <= 8'd0;
            target_r       <= '0;
            inning_over_r  <= 1'b0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
            tie_r          <= 1'b0;
            ball_done_r    <= 1'b0;
            last_outcome_r <= 4'd0;
        end else begin
            ball_done_r <= accept_s;
            if (accept_s) begin
                last_outcome_r <= lfsr_out;
                case (state_r)
                    S_INN1: begin
                        t1_runs_r  <= runs_next_s;
                        t1_legal_r <= legal_next_s;
                        t1_wkts_r  <= wkts_next_s;
                        if (end_s) begin
                            state_r       <= S_INN2;
                            inning_over_r <= 1'b1;
                            target_r      <= {1'b0, runs_next_s} + {{RUN_W{1'b0}}, 1'b1};
                        end
                    end
                    S_INN2: begin
                        t2_runs_r  <= runs_next_s;
                        t2_legal_r <= legal_next_s;
                        t2_wkts_r  <= wkts_next_s;
                        // A successful chase ends the match even on an extra.
                        if (runs_next_s > t1_runs_r) begin
                            state_r     <= S_DONE;
                            game_over_r <= 1'b1;
                            winner_r    <= 1'b1;
                        end else if (end_s) begin
                            state_r     <= S_DONE;
                            game_over_r <= 1'b1;
                            winner_r    <= 1'b0;
                            tie_r       <= (runs_next_s == t1_runs_r);
                        end
                    end
                    default: begin
                        state_r <= S_DONE;
                    end
                endcase
            end
        end
    end

    assign t1_runs      = t1_runs_r;
    assign t2_runs      = t2_runs_r;
    assign t1_wkts      = t1_wkts_r;
    assign t2_wkts      = t2_wkts_r;
    assign t1_legal     = t1_legal_r;
    assign t2_legal     = t2_legal_r;
    assign target       = target_r;
    assign inning_over  = inning_over_r;
    assign game_over    = game_over_r;
    assign winner       = winner_r;
    assign tie          = tie_r;
    assign ball_done    = ball_done_r;
    assign last_outcome = last_outcome_r;

endmodule

// File: doc/innings_controller.md
Name: innings_controller

Overview:
- Match-level scorer and innings sequencer, clocked on the system clock.
- Consumes one debounced, edge-detected delivery strobe plus the 4-bit LFSR outcome per delivery.
- Accumulates runs, wickets and legal deliveries for each team.
- Produces inning_over, game_over and winner for the ball counter, score comparator and BCD display control.

Parameters:
- MAX_BALLS, 120: legal deliveries per innings (20 overs).
- MAX_WKTS, 10: wickets that end an innings.
- RUN_W, 10: width of the run totals; totals saturate at 2^RUN_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ball_pulse  in  1  one-cycle strobe: a delivery was bowled.
- lfsr_out  in  4  delivery outcome code, sampled with ball_pulse.
- team_sw  in  1  team-view switch held; deliveries are ignored while high.
- new_match  in  1  one-cycle synchronous clear to a fresh match.
- t1_runs, t2_runs  out  RUN_W  run totals.
- t1_wkts, t2_wkts  out  4  wickets fallen.
- t1_legal, t2_legal  out  8  legal deliveries bowled.
- target  out  RUN_W+1  t1_runs+1, valid while inning_over=1.
- inning_over  out  1  high from the end of innings 1 until reset or new_match.
- game_over  out  1  match decided.
- winner  out  1  0 = team 1, 1 = team 2; valid only when game_over=1 and tie=0.
- tie  out  1  scores level at the end of the match.
- ball_done  out  1  one-cycle pulse: a delivery was applied to the score.
- last_outcome  out  4  code of the last applied delivery.

Behaviour:
- Reset: rst_n low asynchronously forces state S_INN1 and all outputs to 0.
- new_match: same clear as reset, but synchronous. It has priority over ball_pulse in the same cycle; that delivery is dropped.

Outcome decode (lfsr_out -> runs, legal, wicket):
- 0 -> 0, legal
- 1 -> 1, legal
- 2 -> 2, legal
- 3 -> 3, legal
- 4 -> 4, legal
- 5 -> wide: +1 run, not legal
- 6 -> 6, legal
- 7 -> no-ball: +1 run, not legal
- 8 -> wicket, 0 runs, legal
- 9 -> 1, legal
- 10 -> 0, legal
- 11 -> 2, legal
- 12 -> wicket, legal
- 13 -> 4, legal
- 14 -> 1, legal
- 15 -> 0, legal

Acceptance:
- A delivery is accepted when ball_pulse=1, team_sw=0 and state != S_DONE.
- An accepted delivery updates the batting team's counters on the same clock edge.
- ball_done and last_outcome are registered on that edge (1-cycle latency).
- Deliveries that are not accepted cause no update and no ball_done.

FSM:
- S_INN1: team 1 bats.
  - After an accepted delivery, if t1_legal==MAX_BALLS or t1_wkts==MAX_WKTS, go to S_INN2.
  - inning_over rises on that same edge.
- S_INN2: team 2 bats. Exit conditions are evaluated on the post-update values:
  - t2_runs > t1_runs -> S_DONE, winner=1.
  - Else if t2_legal==MAX_BALLS or t2_wkts==MAX_WKTS:
    - t2_runs < t1_runs -> winner=0.
    - Equal -> tie=1, winner=0.
    - Then S_DONE.
- S_DONE: game_over=1; inning_over remains 1; all counters frozen.

Width and arithmetic rules:
- Run addition saturates at 2^RUN_W-1.
- Legal-delivery and wicket counters never exceed MAX_BALLS and MAX_WKTS, because the FSM exits on reaching them.
- Comparisons are unsigned.
- A chase-winning wide or no-ball ends the match even though it is not legal.

Decomposition:
- cricket_pkg holds:
  - state typedef {S_INN1, S_INN2, S_DONE};
  - outcome constants OC_WIDE=5, OC_NOBALL=7, OC_WKT_A=8, OC_WKT_B=12;
  - the decode function returning {runs[2:0], legal, wicket}.
- One combinational sub-module, outcome_decoder (lfsr_out -> runs, legal, wicket), wraps that function so it can be unit-tested alone.
- The FSM and counters stay in innings_controller.

Test Plan:
- Reset mid-match (rst_n low for 3 cycles during S_INN2) -> all outputs read 0, state S_INN1.
- In S_INN1, apply codes 6,5,7,4 -> t1_runs=12, t1_legal=2, four ball_done pulses.
- Apply 10 wicket codes (8/12) in innings 1 -> inning_over=1 after the 10th delivery; target=t1_runs+1; subsequent deliveries go to team 2.
- Set t1_runs=5, then team 2 scores 4,0,2 -> game_over=1 and winner=1 on the edge of the third delivery; later ball_pulses produce no ball_done.
- Exhaust innings 2 with 120 code-0 deliveries and t1_runs=0 -> tie=1, game_over=1; repeat with t1_runs=3 -> winner=0.
- Coverage of drop conditions:
  - ball_pulse with team_sw=1 -> no update;
  - ball_pulse together with new_match -> cleared, delivery dropped;
  - MAX_BALLS=6 override -> inning_over after 6 legal deliveries, with wides excluded from the count.
